// File: rtl/phy_regfile_block_pkg.sv
// -----------------------------------------------------------------------------
// phy_regfile_block_pkg
// Shared configuration constants for the physical register file.
//   PHY_REG_NUM       : number of physical registers
//   PHY_REG_ID_WIDTH  : width of a physical register id
//   REG_DATA_WIDTH    : width of one register data word
//   READREG_WIDTH     : readreg/issue read slots (two source operands each)
//   WB_WIDTH          : writeback ports
//   COMMIT_WIDTH      : commit invalidate ports
// -----------------------------------------------------------------------------
package phy_regfile_block_pkg;

  localparam int PHY_REG_NUM      = 64;
  localparam int PHY_REG_ID_WIDTH = 6;
  localparam int REG_DATA_WIDTH   = 32;
  localparam int READREG_WIDTH    = 2;
  localparam int WB_WIDTH         = 4;
  localparam int COMMIT_WIDTH     = 2;

endpackage : phy_regfile_block_pkg

// File: rtl/phy_regfile_block.sv
// -----------------------------------------------------------------------------
// phy_regfile_block
// Physical register file: PHY_REG_NUM data words, each with a valid bit.
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   readreg_phyf_id               : readreg-stage source ids  [slot][operand]
//   phyf_readreg_data / _valid    : readreg-stage data / valid
//   issue_phyf_id                 : issue-stage source ids    [slot][operand]
//   phyf_issue_data / _valid      : issue-stage data / valid
//   wb_phyf_id/_data/_we          : writeback ports (highest index wins)
//   commit_phyf_id/_invalid       : commit-time valid clears
//   commit_phyf_flush_id/_invalid : flush-time valid clear
//   commit_phyf_data_valid        : checkpointed valid vector
//   commit_phyf_data_valid_restore: load valid bits from the checkpoint
//
// Reads are purely combinational from the registered state, so a write is
// visible only after the clock edge that stores it (no write bypass).
// -----------------------------------------------------------------------------
module phy_regfile_block
  import phy_regfile_block_pkg::*;
(
  input  logic                                                    clk,
  input  logic                                                    rst,

  input  logic [READREG_WIDTH-1:0][1:0][PHY_REG_ID_WIDTH-1:0]     readreg_phyf_id,
  output logic [READREG_WIDTH-1:0][1:0][REG_DATA_WIDTH-1:0]       phyf_readreg_data,
  output logic [READREG_WIDTH-1:0][1:0]                           phyf_readreg_data_valid,

  input  logic [READREG_WIDTH-1:0][1:0][PHY_REG_ID_WIDTH-1:0]     issue_phyf_id,
  output logic [READREG_WIDTH-1:0][1:0][REG_DATA_WIDTH-1:0]       phyf_issue_data,
  output logic [READREG_WIDTH-1:0][1:0]                           phyf_issue_data_valid,

  input  logic [WB_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]               wb_phyf_id,
  input  logic [WB_WIDTH-1:0][REG_DATA_WIDTH-1:0]                 wb_phyf_data,
  input  logic [WB_WIDTH-1:0]                                     wb_phyf_we,

  input  logic [COMMIT_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]           commit_phyf_id,
  input  logic [COMMIT_WIDTH-1:0]                                 commit_phyf_invalid,
  input  logic [PHY_REG_ID_WIDTH-1:0]                             commit_phyf_flush_id,
  input  logic                                                    commit_phyf_flush_invalid,
  input  logic [PHY_REG_NUM-1:0]                                  commit_phyf_data_valid,
  input  logic                                                    commit_phyf_data_valid_restore
);

  logic [PHY_REG_NUM-1:0][REG_DATA_WIDTH-1:0] data_q, data_d;
  logic [PHY_REG_NUM-1:0]                     valid_q, valid_d;

  // Next-state computation. The order of the statements encodes priority:
  // later assignments override earlier ones.
  always_comb begin
    // NOTE: every combinational output gets a default first (hold current
    // state), so no path through the block leaves it unassigned -> no latch.
    data_d  = data_q;
    valid_d = valid_q;

    // NOTE: blocking '=' here on purpose -- each loop iteration must see the
    // previous one's result so the highest writeback port index wins.
    for (int i = 0; i < WB_WIDTH; i++) begin
      if (wb_phyf_we[i]) begin
        data_d[wb_phyf_id[i]]  = wb_phyf_data[i];
        valid_d[wb_phyf_id[i]] = 1'b1;
      end
    end

    // Invalidates come after writeback so they win on a shared id; data
    // written that cycle is still kept.
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (commit_phyf_invalid[i]) begin
        valid_d[commit_phyf_id[i]] = 1'b0;
      end
    end

    if (commit_phyf_flush_invalid) begin
      valid_d[commit_phyf_flush_id] = 1'b0;
    end

    // Checkpoint restore replaces the whole valid vector; data writes above
    // are unaffected.
    if (commit_phyf_data_valid_restore) begin
      valid_d = commit_phyf_data_valid;
    end
  end

  // NOTE: the storage array is reset as well, not just the valid bits: reads
  // after reset must return zero data, so this array is built from resettable
  // flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Read ports: one independent mux per slot/operand for each stage.
  for (genvar s = 0; s < READREG_WIDTH; s++) begin : g_slot
    for (genvar o = 0; o < 2; o++) begin : g_opnd
      assign phyf_readreg_data[s][o]       = data_q[readreg_phyf_id[s][o]];
      assign phyf_readreg_data_valid[s][o] = valid_q[readreg_phyf_id[s][o]];
      assign phyf_issue_data[s][o]         = data_q[issue_phyf_id[s][o]];
      assign phyf_issue_data_valid[s][o]   = valid_q[issue_phyf_id[s][o]];
    end
  end

endmodule : phy_regfile_block

// File: tb/tb_phy_regfile_block.sv
// -----------------------------------------------------------------------------
// tb_phy_regfile_block
// Self-checking bench for phy_regfile_block. Each scenario task drives
// stimulus, pushes the expected (id, data, valid) results into a scoreboard
// queue, and then drains the queue by steering every read port to the id and
// comparing against the expectation.
// -----------------------------------------------------------------------------
module tb_phy_regfile_block;
  import phy_regfile_block_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [READREG_WIDTH-1:0][1:0][PHY_REG_ID_WIDTH-1:0] readreg_phyf_id = '0;
  logic [READREG_WIDTH-1:0][1:0][REG_DATA_WIDTH-1:0]   phyf_readreg_data;
  logic [READREG_WIDTH-1:0][1:0]                       phyf_readreg_data_valid;
  logic [READREG_WIDTH-1:0][1:0][PHY_REG_ID_WIDTH-1:0] issue_phyf_id = '0;
  logic [READREG_WIDTH-1:0][1:0][REG_DATA_WIDTH-1:0]   phyf_issue_data;
  logic [READREG_WIDTH-1:0][1:0]                       phyf_issue_data_valid;
  logic [WB_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]           wb_phyf_id = '0;
  logic [WB_WIDTH-1:0][REG_DATA_WIDTH-1:0]             wb_phyf_data = '0;
  logic [WB_WIDTH-1:0]                                 wb_phyf_we = '0;
  logic [COMMIT_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]       commit_phyf_id = '0;
  logic [COMMIT_WIDTH-1:0]                             commit_phyf_invalid = '0;
  logic [PHY_REG_ID_WIDTH-1:0]                         commit_phyf_flush_id = '0;
  logic                                                commit_phyf_flush_invalid = 1'b0;
  logic [PHY_REG_NUM-1:0]                              commit_phyf_data_valid = '0;
  logic                                                commit_phyf_data_valid_restore = 1'b0;

  phy_regfile_block dut (
    .clk                            (clk),
    .rst                            (rst),
    .readreg_phyf_id                (readreg_phyf_id),
    .phyf_readreg_data              (phyf_readreg_data),
    .phyf_readreg_data_valid        (phyf_readreg_data_valid),
    .issue_phyf_id                  (issue_phyf_id),
    .phyf_issue_data                (phyf_issue_data),
    .phyf_issue_data_valid          (phyf_issue_data_valid),
    .wb_phyf_id                     (wb_phyf_id),
    .wb_phyf_data                   (wb_phyf_data),
    .wb_phyf_we                     (wb_phyf_we),
    .commit_phyf_id                 (commit_phyf_id),
    .commit_phyf_invalid            (commit_phyf_invalid),
    .commit_phyf_flush_id           (commit_phyf_flush_id),
    .commit_phyf_flush_invalid      (commit_phyf_flush_invalid),
    .commit_phyf_data_valid         (commit_phyf_data_valid),
    .commit_phyf_data_valid_restore (commit_phyf_data_valid_restore)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PHY_REG_ID_WIDTH-1:0] id;
    logic [REG_DATA_WIDTH-1:0]   data;
    logic                        valid;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Stimulus helpers (no comparisons here).
  task automatic idle_inputs();
    wb_phyf_we                     = '0;
    commit_phyf_invalid            = '0;
    commit_phyf_flush_invalid      = 1'b0;
    commit_phyf_data_valid_restore = 1'b0;
    commit_phyf_data_valid         = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] id, input logic [31:0] data, input logic valid);
    exp_t e;
    e.id = id; e.data = data; e.valid = valid;
    sb.push_back(e);
  endtask

  task automatic steer(input logic [5:0] id);
    for (int s = 0; s < READREG_WIDTH; s++)
      for (int o = 0; o < 2; o++) begin
        readreg_phyf_id[s][o] = id;
        issue_phyf_id[s][o]   = id;
      end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    exp_t e;
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    push(6'd0, 32'h0, 1'b0);
    push(6'd5, 32'h0, 1'b0);
    push(6'd63, 32'h0, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      steer(e.id); #1;
      checks++;
      if ({phyf_readreg_data, phyf_readreg_data_valid} !== {{4{e.data}}, {4{e.valid}}}) begin
        failures++;
        $display("FAIL reset_readreg id=%0d got data=%h valid=%b exp data=%h valid=%b",
                 e.id, phyf_readreg_data, phyf_readreg_data_valid, e.data, e.valid);
      end
      checks++;
      if ({phyf_issue_data, phyf_issue_data_valid} !== {{4{e.data}}, {4{e.valid}}}) begin
        failures++;
        $display("FAIL reset_issue id=%0d got data=%h valid=%b exp data=%h valid=%b",
                 e.id, phyf_issue_data, phyf_issue_data_valid, e.data, e.valid);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_write_visibility();
    exp_t e;
    wb_phyf_we      = 4'b0011;
    wb_phyf_id[0]   = 6'd5;
    wb_phyf_data[0] = 32'h1234_5678;
    wb_phyf_id[1]   = 6'd0;
    wb_phyf_data[1] = 32'h0BAD_F00D;
    steer(6'd5); #1;
    // Before the edge the write must not be bypassed to the read ports.
    checks++;
    if ({phyf_readreg_data_valid, phyf_issue_data_valid} !== 8'h00) begin
      failures++;
      $display("FAIL no_bypass_valid got rr=%b is=%b exp 0000/0000",
               phyf_readreg_data_valid, phyf_issue_data_valid);
    end
    checks++;
    if (phyf_readreg_data !== '0) begin
      failures++;
      $display("FAIL no_bypass_data got %h exp 0", phyf_readreg_data);
    end
    tick();
    idle_inputs();
    push(6'd5, 32'h1234_5678, 1'b1);
    push(6'd0, 32'h0BAD_F00D, 1'b1);
    push(6'd6, 32'h0, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      steer(e.id); #1;
      checks++;
      if ({phyf_readreg_data, phyf_readreg_data_valid} !== {{4{e.data}}, {4{e.valid}}}) begin
        failures++;
        $display("FAIL write_readreg id=%0d got data=%h valid=%b exp data=%h valid=%b",
                 e.id, phyf_readreg_data, phyf_readreg_data_valid, e.data, e.valid);
      end
      checks++;
      if ({phyf_issue_data, phyf_issue_data_valid} !== {{4{e.data}}, {4{e.valid}}}) begin
        failures++;
        $display("FAIL write_issue id=%0d got data=%h valid=%b exp data=%h valid=%b",
                 e.id, phyf_issue_data, phyf_issue_data_valid, e.data, e.valid);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wb_priority();
    exp_t e;
    wb_phyf_we      = 4'b1011;
    wb_phyf_id[0]   = 6'd7;  wb_phyf_data[0] = 32'h0000_000C;
    wb_phyf_id[1]   = 6'd7;  wb_phyf_data[1] = 32'h0000_000A;
    wb_phyf_id[3]   = 6'd7;  wb_phyf_data[3] = 32'h0000_000B;
    tick();
    idle_inputs();
    push(6'd7, 32'h0000_000B, 1'b1);
    // Second round: ports 0..2 collide, port 3 elsewhere -> port 2 wins.
    wb_phyf_we      = 4'b1111;
    wb_phyf_id[0]   = 6'd8;  wb_phyf_data[0] = 32'h0000_0100;
    wb_phyf_id[1]   = 6'd8;  wb_phyf_data[1] = 32'h0000_0101;
    wb_phyf_id[2]   = 6'd8;  wb_phyf_data[2] = 32'h0000_0102;
    wb_phyf_id[3]   = 6'd10; wb_phyf_data[3] = 32'h0000_0103;
    tick();
    idle_inputs();
    push(6'd8,  32'h0000_0102, 1'b1);
    push(6'd10, 32'h0000_0103, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      steer(e.id); #1;
      checks++;
      if ({phyf_readreg_data, phyf_readreg_data_valid} !== {{4{e.data}}, {4{e.valid}}}) begin
        failures++;
        $display("FAIL wb_prio_readreg id=%0d got data=%h valid=%b exp data=%h valid=%b",
                 e.id, phyf_readreg_data, phyf_readreg_data_valid, e.data, e.valid);
      end
      checks++;
      if ({phyf_issue_data, phyf_issue_data_valid} !== {{4{e.data}}, {4{e.valid}}}) begin
        failures++;
        $display("FAIL wb_prio_issue id=%0d got data=%h valid=%b exp data=%h valid=%b",
                 e.id, phyf_issue_data, phyf_issue_data_valid, e.data, e.valid);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_invalidate_priority();
    exp_t e;
    // id 5 is valid from the write test. Commit port 0 clears id 5 while
    // writeback port 2 writes it; commit port 1 does the same on id 12.
    wb_phyf_we             = 4'b1100;
    wb_phyf_id[2]          = 6'd5;  wb_phyf_data[2] = 32'hDEAD_BEEF;
    wb_phyf_id[3]          = 6'd12; wb_phyf_data[3] = 32'h0000_1212;
    commit_phyf_invalid    = 2'b11;
    commit_phyf_id[0]      = 6'd5;
    commit_phyf_id[1]      = 6'd12;
    tick();
    idle_inputs();
    push(6'd5,  32'hDEAD_BEEF, 1'b0);
    push(6'd12, 32'h0000_1212, 1'b0);
    push(6'd7,  32'h0000_000B, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      steer(e.id); #1;
      checks++;
      if ({phyf_readreg_data, phyf_readreg_data_valid} !== {{4{e.data}}, {4{e.valid}}}) begin
        failures++;
        $display("FAIL inval_readreg id=%0d got data=%h valid=%b exp data=%h valid=%b",
                 e.id, phyf_readreg_data, phyf_readreg_data_valid, e.data, e.valid);
      end
      checks++;
      if ({phyf_issue_data, phyf_issue_data_valid} !== {{4{e.data}}, {4{e.valid}}}) begin
        failures++;
        $display("FAIL inval_issue id=%0d got data=%h valid=%b exp data=%h valid=%b",
                 e.id, phyf_issue_data, phyf_issue_data_valid, e.data, e.valid);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_restore();
    exp_t e;
    wb_phyf_we    = 4'b0111;
    wb_phyf_id[0] = 6'd1; wb_phyf_data[0] = 32'h0000_0011;
    wb_phyf_id[1] = 6'd2; wb_phyf_data[1] = 32'h0000_0022;
    wb_phyf_id[2] = 6'd3; wb_phyf_data[2] = 32'h0000_0033;
    tick();
    idle_inputs();
    // Restore with bits 2 and 40 set; a same-cycle write of id 4 keeps its
    // data but its valid bit comes from the vector (0).
    commit_phyf_data_valid_restore = 1'b1;
    commit_phyf_data_valid         = '0;
    commit_phyf_data_valid[2]      = 1'b1;
    commit_phyf_data_valid[40]     = 1'b1;
    wb_phyf_we    = 4'b0001;
    wb_phyf_id[0] = 6'd4; wb_phyf_data[0] = 32'h0000_0044;
    commit_phyf_invalid = 2'b01;
    commit_phyf_id[0]   = 6'd40;
    tick();
    idle_inputs();
    push(6'd1,  32'h0000_0011, 1'b0);
    push(6'd2,  32'h0000_0022, 1'b1);
    push(6'd3,  32'h0000_0033, 1'b0);
    push(6'd4,  32'h0000_0044, 1'b0);
    push(6'd40, 32'h0000_0000, 1'b1);
    push(6'd7,  32'h0000_000B, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      steer(e.id); #1;
      checks++;
      if ({phyf_readreg_data, phyf_readreg_data_valid} !== {{4{e.data}}, {4{e.valid}}}) begin
        failures++;
        $display("FAIL restore_readreg id=%0d got data=%h valid=%b exp data=%h valid=%b",
                 e.id, phyf_readreg_data, phyf_readreg_data_valid, e.data, e.valid);
      end
      checks++;
      if ({phyf_issue_data, phyf_issue_data_valid} !== {{4{e.data}}, {4{e.valid}}}) begin
        failures++;
        $display("FAIL restore_issue id=%0d got data=%h valid=%b exp data=%h valid=%b",
                 e.id, phyf_issue_data, phyf_issue_data_valid, e.data, e.valid);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] d;
    logic [5:0]  id;
    // Eight consecutive cycles writing ids 32..63 on all four ports; each
    // cycle also commit-invalidates the id port 0 wrote in the cycle before.
    for (int c = 0; c < 8; c++) begin
      wb_phyf_we = 4'b1111;
      for (int i = 0; i < WB_WIDTH; i++) begin
        id = 6'(32 + c * 4 + i);
        d  = $urandom;
        wb_phyf_id[i]   = id;
        wb_phyf_data[i] = d;
        push(id, d, !(i == 0 && c < 7));
      end
      commit_phyf_invalid = (c > 0) ? 2'b01 : 2'b00;
      commit_phyf_id[0]   = 6'(32 + (c - 1) * 4);
      tick();
    end
    idle_inputs();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      steer(e.id); #1;
      checks++;
      if ({phyf_readreg_data, phyf_readreg_data_valid} !== {{4{e.data}}, {4{e.valid}}}) begin
        failures++;
        $display("FAIL b2b_readreg id=%0d got data=%h valid=%b exp data=%h valid=%b",
                 e.id, phyf_readreg_data, phyf_readreg_data_valid, e.data, e.valid);
      end
      checks++;
      if ({phyf_issue_data, phyf_issue_data_valid} !== {{4{e.data}}, {4{e.valid}}}) begin
        failures++;
        $display("FAIL b2b_issue id=%0d got data=%h valid=%b exp data=%h valid=%b",
                 e.id, phyf_issue_data, phyf_issue_data_valid, e.data, e.valid);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush_and_reset();
    exp_t e;
    wb_phyf_we    = 4'b0001;
    wb_phyf_id[0] = 6'd9; wb_phyf_data[0] = 32'h0000_0099;
    tick();
    idle_inputs();
    commit_phyf_flush_invalid = 1'b1;
    commit_phyf_flush_id      = 6'd9;
    tick();
    idle_inputs();
    push(6'd9, 32'h0000_0099, 1'b0);
    push(6'd2, 32'h0000_0022, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      steer(e.id); #1;
      checks++;
      if ({phyf_readreg_data, phyf_readreg_data_valid} !== {{4{e.data}}, {4{e.valid}}}) begin
        failures++;
        $display("FAIL flush_readreg id=%0d got data=%h valid=%b exp data=%h valid=%b",
                 e.id, phyf_readreg_data, phyf_readreg_data_valid, e.data, e.valid);
      end
      checks++;
      if ({phyf_issue_data, phyf_issue_data_valid} !== {{4{e.data}}, {4{e.valid}}}) begin
        failures++;
        $display("FAIL flush_issue id=%0d got data=%h valid=%b exp data=%h valid=%b",
                 e.id, phyf_issue_data, phyf_issue_data_valid, e.data, e.valid);
      end
    end
    // Mid-stream reset with a write and a restore pending: reset wins.
    wb_phyf_we    = 4'b0001;
    wb_phyf_id[0] = 6'd21; wb_phyf_data[0] = 32'h0000_2121;
    commit_phyf_data_valid_restore = 1'b1;
    commit_phyf_data_valid         = '1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    push(6'd21, 32'h0, 1'b0);
    push(6'd2,  32'h0, 1'b0);
    push(6'd63, 32'h0, 1'b0);
    push(6'd0,  32'h0, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      steer(e.id); #1;
      checks++;
      if ({phyf_readreg_data, phyf_readreg_data_valid} !== {{4{e.data}}, {4{e.valid}}}) begin
        failures++;
        $display("FAIL rst_mid_readreg id=%0d got data=%h valid=%b exp data=%h valid=%b",
                 e.id, phyf_readreg_data, phyf_readreg_data_valid, e.data, e.valid);
      end
      checks++;
      if ({phyf_issue_data, phyf_issue_data_valid} !== {{4{e.data}}, {4{e.valid}}}) begin
        failures++;
        $display("FAIL rst_mid_issue id=%0d got data=%h valid=%b exp data=%h valid=%b",
                 e.id, phyf_issue_data, phyf_issue_data_valid, e.data, e.valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_visibility();
    test_wb_priority();
    test_invalidate_priority();
    test_restore();
    test_back_to_back();
    test_flush_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_phy_regfile_block
